i2c_write_sequencer: RTL

- I2C master write controller that drives the configuration bus, e.g. audio codec register setup.
- Derives SCL internally from the system clock.
- Sequences START, address byte, two data bytes and STOP, checking ACK after each byte.
- Sits between the configuration FSM and the I2C pins, and replaces a free-running divided SCL with a controlled, transaction-gated one.

---
 rtl/i2c_pkg.sv | 75 +++++++
 rtl/i2c_quarter_tick.sv | 59 +++++
 rtl/i2c_write_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
//   Shared definitions for the I2C write sequencer.
//   - state_t      : sequencer FSM states
//   - NUM_BYTES    : bytes per transaction (address + two payload bytes)
//   - BITS_PER_BYTE: data bits per byte (ACK slot not included)
//   - byte_of()    : selects the byte shifted out for a given byte index
//   - bus_levels() : SCL / SDA-pull-down levels for a {state, quarter} slot
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START_C = 3'd1,
        BIT     = 3'd2,
        ACK     = 3'd3,
        STOP_C  = 3'd4,
        FINISH  = 3'd5
    } state_t;

    localparam int unsigned NUM_BYTES     = 3;
    localparam int unsigned BITS_PER_BYTE = 8;

    // Byte 0 is the address with the write (R/W = 0) bit appended,
    // then the payload high byte, then the payload low byte.
    function automatic logic [7:0] byte_of(input logic [1:0]  idx,
                                           input logic [6:0]  addr,
                                           input logic [15:0] data);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {addr, 1'b0};
            2'd1:    b = data[15:8];
            default: b = data[7:0];
        endcase
        return b;
    endfunction

    // Returns {scl, oe} for one quarter of a bus phase. oe = 1 pulls SDA low.
    // Outside the active phases the bus is idle: SCL high, SDA released.
    function automatic logic [1:0] bus_levels(input state_t     st,
                                              input logic [1:0] q,
                                              input logic       bit_val);
        logic scl;
        logic oe;
        scl = 1'b1;
        oe  = 1'b0;
        case (st)
            START_C: begin
                // SDA falls while SCL is high, then SCL drops.
                scl = (q != 2'd3);
                oe  = (q != 2'd0);
            end
            BIT: begin
                // SDA settles during the low half, held through the high half.
                scl = q[1];
                oe  = ~bit_val;
            end
            ACK: begin
                scl = q[1];
                oe  = 1'b0;
            end
            STOP_C: begin
                // SCL rises with SDA low, then SDA is released while SCL is high.
                scl = (q != 2'd0);
                oe  = ~q[1];
            end
            default: begin
                scl = 1'b1;
                oe  = 1'b0;
            end
        endcase
        return {scl, oe};
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// ---------------------------------------------------------------------------
// i2c_quarter_tick
//   Quarter-period timebase for the I2C sequencer. Counts system clocks while
//   enabled and emits a one-cycle tick every QUARTER clocks, advancing a
//   2-bit quarter index that wraps 3 -> 0.
//
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     en       in   count enable
//     clr      in   synchronous clear of counter and quarter index
//     tick     out  high in the last cycle of each quarter (only while en)
//     quarter  out  index of the quarter currently in progress
// ---------------------------------------------------------------------------
module i2c_quarter_tick #(
    parameter int unsigned QUARTER     = 125,
    parameter int unsigned count_width = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic       tick,
    output logic [1:0] quarter
);

    localparam logic [count_width-1:0] LAST = count_width'(QUARTER - 1);

    logic [count_width-1:0] count_q, count_d;
    logic [1:0]             q_q, q_d;

    assign tick    = en && (count_q == LAST);
    assign quarter = q_q;

    always_comb begin
        count_d = count_q;
        q_d     = q_q;
        if (clr) begin
            count_d = '0;
            q_d     = 2'd0;
        end else if (tick) begin
            count_d = '0;
            q_d     = q_q + 2'd1;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            q_q     <= 2'd0;
        end else begin
            count_q <= count_d;
            q_q     <= q_d;
        end
    end

endmodule

// File: rtl/i2c_write_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_write_sequencer
//   I2C master write controller: START, address byte (write), two payload
//   bytes, STOP, with ACK checked after every byte. SCL is generated from
//   the system clock only while a transaction is running.
//
//   Handshake: a request is accepted in any cycle where START = 1 and the
//   sequencer is idle (BUSY = 0); DEV_ADDR / REG_DATA are captured in that
//   cycle. BUSY rises the next cycle. Requests while BUSY = 1, or in the
//   single DONE cycle, are ignored. DONE is a one-cycle completion pulse.
//
//   Ports:
//     CLK_IN       in   system clock
//     RESET_N      in   asynchronous active-low reset
//     START        in   transaction request
//     DEV_ADDR     in   7-bit slave address
//     REG_DATA     in   payload, [15:8] sent first
//     BUSY         out  transaction in progress
//     DONE         out  one-cycle end-of-transaction pulse
//     ACK_ERR      out  slave NACKed during the last transaction
//     I2C_SCLK     out  SCL (push-pull)
//     I2C_SDAT_OE  out  1 pulls SDA low, 0 releases it
//     I2C_SDAT_IN  in   SDA level seen on the pin
// ---------------------------------------------------------------------------
module i2c_write_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned ref_rate    = 50000000,
    parameter int unsigned target_rate = 100000,
    parameter int unsigned count_width = 8
) (
    input  logic        CLK_IN,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [6:0]  DEV_ADDR,
    input  logic [15:0] REG_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ACK_ERR,
    output logic        I2C_SCLK,
    output logic        I2C_SDAT_OE,
    input  logic        I2C_SDAT_IN
);

    localparam int unsigned QUARTER   = ref_rate / (4 * target_rate);
    localparam logic [1:0]  LAST_BYTE = 2'(NUM_BYTES - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(BITS_PER_BYTE - 1);

    state_t      state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        nack_q, nack_d;
    logic        scl_q, scl_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;

    logic        accept;
    logic        cnt_en;
    logic        tick;
    logic [1:0]  quarter;
    logic [7:0]  cur_byte;
    logic        cur_bit;
    logic [7:0]  nxt_byte;
    logic        nxt_bit;

    assign accept = (state_q == IDLE) && START;
    assign cnt_en = (state_q == START_C) || (state_q == BIT) ||
                    (state_q == ACK)     || (state_q == STOP_C);

    i2c_quarter_tick #(
        .QUARTER     (QUARTER),
        .count_width (count_width)
    ) u_tick (
        .clk     (CLK_IN),
        .rst_n   (RESET_N),
        .en      (cnt_en),
        .clr     (accept),
        .tick    (tick),
        .quarter (quarter)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        nack_d     = nack_q;
        scl_d      = scl_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;

        cur_byte = byte_of(byte_idx_q, addr_q, data_q);
        cur_bit  = cur_byte[3'd7 - bit_idx_q];
        nxt_byte = 8'h00;
        nxt_bit  = 1'b1;

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d    = START_C;
                    addr_d     = DEV_ADDR;
                    data_d     = REG_DATA;
                    byte_idx_d = 2'd0;
                    bit_idx_d  = 3'd0;
                    nack_d     = 1'b0;
                    ack_err_d  = 1'b0;
                    busy_d     = 1'b1;
                    {scl_d, oe_d} = bus_levels(START_C, 2'd0, 1'b1);
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                if (tick) begin
                    if (quarter != 2'd3) begin
                        // Same phase, next quarter.
                        {scl_d, oe_d} = bus_levels(state_q, quarter + 2'd1, cur_bit);
                        // Slave response is taken at the end of the first
                        // SCL-high quarter of the ACK slot.
                        if ((state_q == ACK) && (quarter == 2'd2) && I2C_SDAT_IN) begin
                            nack_d    = 1'b1;
                            ack_err_d = 1'b1;
                        end
                    end else begin
                        case (state_q)
                            START_C: begin
                                state_d    = BIT;
                                byte_idx_d = 2'd0;
                                bit_idx_d  = 3'd0;
                            end
                            BIT: begin
                                if (bit_idx_q == LAST_BIT) begin
                                    state_d = ACK;
                                end else begin
                                    bit_idx_d = bit_idx_q + 3'd1;
                                end
                            end
                            ACK: begin
                                // A NACK ends the transfer; remaining bytes skipped.
                                if (nack_q || (byte_idx_q == LAST_BYTE)) begin
                                    state_d = STOP_C;
                                end else begin
                                    state_d    = BIT;
                                    byte_idx_d = byte_idx_q + 2'd1;
                                    bit_idx_d  = 3'd0;
                                end
                            end
                            STOP_C: begin
                                state_d = FINISH;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                            default: begin
                                state_d = IDLE;
                            end
                        endcase
                        // Levels for quarter 0 of whatever phase comes next.
                        nxt_byte      = byte_of(byte_idx_d, addr_q, data_q);
                        nxt_bit       = nxt_byte[3'd7 - bit_idx_d];
                        {scl_d, oe_d} = bus_levels(state_d, 2'd0, nxt_bit);
                    end
                end
            end
        endcase
    end

    // Reset drops the bus to idle at once; an interrupted transfer gets no STOP.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            addr_q     <= 7'd0;
            data_q     <= 16'd0;
            byte_idx_q <= 2'd0;
            bit_idx_q  <= 3'd0;
            nack_q     <= 1'b0;
            scl_q      <= 1'b1;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            nack_q     <= nack_d;
            scl_q      <= scl_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign ACK_ERR     = ack_err_q;
    assign I2C_SCLK    = scl_q;
    assign I2C_SDAT_OE = oe_q;

endmodule
